// File: rtl/avr_pkg.sv
// Shared AVR data-memory definitions: arbiter states and default bus widths.
package avr_pkg;

    typedef enum logic [0:0] {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_state_t;

    localparam int AVR_ADDR_W = 16;
    localparam int AVR_DATA_W = 8;

endpackage

// File: rtl/avr_dmem_arbiter.sv
// Single-port data SRAM arbiter between the AVR core data port and a DMA/debug requester.
// CPU has priority; a wait counter forces starved DMA through, a burst counter bounds the CPU hold-off.
module avr_dmem_arbiter
    import avr_pkg::*;
#(
    parameter int ADDR_W    = AVR_ADDR_W,
    parameter int DATA_W    = AVR_DATA_W,
    parameter int MAX_WAIT  = 4,
    parameter int DMA_BURST = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(DMA_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(DMA_BURST);

    arb_state_t        state_r, state_nxt_s;
    logic [WW-1:0]     wait_cnt_r, wait_cnt_nxt_s;
    logic [BW-1:0]     burst_cnt_r, burst_cnt_nxt_s;
    logic              cpu_grant_s, dma_grant_s;
    logic              rd_cpu_r, rd_dma_r;
    logic [DATA_W-1:0] cpu_rdata_r, dma_rdata_r;

    // Grant selection and next-state/burst computation.
    // The forced DMA grant that enters ARB_DMA already counts as the first burst grant.
    always_comb begin
        cpu_grant_s     = 1'b0;
        dma_grant_s     = 1'b0;
        state_nxt_s     = state_r;
        burst_cnt_nxt_s = burst_cnt_r;
        if (RST) begin
            state_nxt_s = ARB_CPU;
        end else begin
            case (state_r)
                ARB_CPU: begin
                    if (dma_req && (!cpu_req || wait_cnt_r == WAIT_MAX)) begin
                        dma_grant_s = 1'b1;
                        if (cpu_req) begin
                            state_nxt_s     = ARB_DMA;
                            burst_cnt_nxt_s = BW'(1);
                        end else begin
                            state_nxt_s = ARB_CPU;
                        end
                    end else if (cpu_req) begin
                        cpu_grant_s = 1'b1;
                    end else begin
                        cpu_grant_s = 1'b0;
                    end
                end
                ARB_DMA: begin
                    if (dma_req && (!cpu_req || burst_cnt_r != BURST_MAX)) begin
                        dma_grant_s = 1'b1;
                        if (cpu_req) begin
                            burst_cnt_nxt_s = burst_cnt_r + BW'(1);
                        end else begin
                            burst_cnt_nxt_s = burst_cnt_r;
                        end
                    end else if (cpu_req) begin
                        cpu_grant_s = 1'b1;
                    end else begin
                        cpu_grant_s = 1'b0;
                    end
                    if (!dma_req || (cpu_req && burst_cnt_nxt_s == BURST_MAX)) begin
                        state_nxt_s = ARB_CPU;
                    end else begin
                        state_nxt_s = ARB_DMA;
                    end
                end
                default: begin
                    state_nxt_s = ARB_CPU;
                end
            endcase
        end
    end

    // Starvation counter: counts denied DMA cycles, saturating at MAX_WAIT.
    always_comb begin
        if (!dma_req || dma_grant_s) begin
            wait_cnt_nxt_s = {WW{1'b0}};
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_nxt_s = wait_cnt_r + WW'(1);
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // RAM port mux; idle cycles drive all zeros.
    always_comb begin
        mem_en = cpu_grant_s | dma_grant_s;
        if (cpu_grant_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_grant_s) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Handshake and read-return outputs; forced quiet while RST is asserted.
    always_comb begin
        cpu_stall = cpu_req & ~cpu_grant_s & ~RST;
        dma_gnt   = dma_req & dma_grant_s;
        if (RST) begin
            dma_rvalid = 1'b0;
            cpu_rdata  = {DATA_W{1'b0}};
            dma_rdata  = {DATA_W{1'b0}};
        end else begin
            dma_rvalid = rd_dma_r;
            cpu_rdata  = rd_cpu_r ? mem_rdata : cpu_rdata_r;
            dma_rdata  = rd_dma_r ? mem_rdata : dma_rdata_r;
        end
    end

    // Arbiter state, counters, read owner tags and held read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ARB_CPU;
            wait_cnt_r  <= {WW{1'b0}};
            burst_cnt_r <= {BW{1'b0}};
            rd_cpu_r    <= 1'b0;
            rd_dma_r    <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
            dma_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            rd_cpu_r    <= cpu_grant_s & ~cpu_we;
            rd_dma_r    <= dma_grant_s & ~dma_we;
            cpu_rdata_r <= rd_cpu_r ? mem_rdata : cpu_rdata_r;
            dma_rdata_r <= rd_dma_r ? mem_rdata : dma_rdata_r;
        end
    end

endmodule
